// File: rtl/qpmm_final_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : qpmm_final_reducer
//  Description : Canonicalises the lazily reduced BN254 QPMM product (< 4p)
//                into [0, p) with a two-stage conditional subtraction
//                (2p, then p). Results are buffered in a show-ahead FIFO with
//                valid/ready output, an almost_full issue-throttle hint and
//                sticky range/overflow error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module qpmm_final_reducer #(
   parameter int             W_IN      = 256,
   parameter int             W_P       = 254,
   parameter logic [W_P-1:0] P         = 254'h2523648240000001ba344d80000000086121000000000013a700000000000013,
   parameter int             W_TAG     = 8,
   parameter int             DEPTH     = 8,
   parameter int             AF_MARGIN = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      in_valid,
   input  logic [W_IN-1:0]           in_z,
   input  logic [W_TAG-1:0]          in_tag,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [W_P-1:0]            out_data,
   output logic [W_TAG-1:0]          out_tag,
   output logic                      almost_full,
   output logic                      err_range,
   output logic                      err_overflow,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 2;

   // Multiples of the modulus, zero-extended to the subtractor width so the
   // borrow out of the top bit is the comparison result.
   localparam logic [W_IN:0] C_P1 = {{(W_IN + 1 - W_P){1'b0}}, P};
   localparam logic [W_IN:0] C_P2 = C_P1 << 1;
   localparam logic [W_IN:0] C_P4 = C_P1 << 2;

   // ------------------------------------------------------------------------
   // Stage 1 : subtract 2p when in_z >= 2p, flag in_z >= 4p
   // ------------------------------------------------------------------------
   logic              w_lt2p;
   logic [W_IN-1:0]   w_d2_lo;
   logic              w_lt4p;
   logic [W_IN-1:0]   w_unused_d4;

   assign {w_lt2p, w_d2_lo}     = {1'b0, in_z} - C_P2;
   assign {w_lt4p, w_unused_d4} = {1'b0, in_z} - C_P4;

   logic              r_s1_v;
   logic [W_IN-1:0]   r_s1_z;
   logic [W_TAG-1:0]  r_s1_tag;
   logic              r_s1_rng;

   // Stage-1 register: valid always tracks the input, payload loads on valid.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_s1_v   <= 1'b0;
         r_s1_z   <= '0;
         r_s1_tag <= '0;
         r_s1_rng <= 1'b0;
      end else begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_s1_z   <= w_lt2p ? in_z : w_d2_lo;
            r_s1_tag <= in_tag;
            r_s1_rng <= ~w_lt4p;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 : subtract p when s1_z >= p, truncate to W_P bits
   // ------------------------------------------------------------------------
   logic                  w_lt1p;
   logic [W_IN-W_P-1:0]   w_unused_d1;
   logic [W_P-1:0]        w_d1_lo;
   logic [W_P-1:0]        w_s2_z_next;

   assign {w_lt1p, w_unused_d1, w_d1_lo} = {1'b0, r_s1_z} - C_P1;
   assign w_s2_z_next = w_lt1p ? r_s1_z[W_P-1:0] : w_d1_lo;

   logic              r_s2_v;
   logic [W_P-1:0]    r_s2_z;
   logic [W_TAG-1:0]  r_s2_tag;
   logic              r_s2_rng;

   // Stage-2 register: final canonical value plus tag and range flag.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_s2_v   <= 1'b0;
         r_s2_z   <= '0;
         r_s2_tag <= '0;
         r_s2_rng <= 1'b0;
      end else begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_z   <= w_s2_z_next;
            r_s2_tag <= r_s1_tag;
            r_s2_rng <= r_s1_rng;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Show-ahead FIFO
   // ------------------------------------------------------------------------
   logic [W_TAG+W_P-1:0]  r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_count;
   logic [W_TAG+W_P-1:0]  w_head;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_wr_en;
   logic                  w_drop;

   assign w_head    = r_mem[r_rd_ptr];
   assign out_valid = (r_count != '0);
   assign w_full    = (r_count == (AW + 1)'(DEPTH));
   assign w_pop     = out_valid && out_ready;
   // A write into a full FIFO still lands when the head leaves the same cycle.
   assign w_wr_en   = r_s2_v && (!w_full || w_pop);
   assign w_drop    = r_s2_v && w_full && !w_pop;

   // Head is forced to zero while empty so stale storage never shows.
   assign out_data  = out_valid ? w_head[W_P-1:0]      : '0;
   assign out_tag   = out_valid ? w_head[W_P +: W_TAG] : '0;
   assign count     = r_count;

   // Storage array write; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= {r_s2_tag, r_s2_z};
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + (AW + 1)'(1);
         end else if (!w_wr_en && w_pop) begin
            r_count <= r_count - (AW + 1)'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Credits, almost_full and sticky error flags
   // ------------------------------------------------------------------------
   logic [CW-1:0]  w_credits;
   logic           w_af_next;
   logic           r_af;
   logic           r_err_range;
   logic           r_err_overflow;

   // Entries already buffered plus those still in the pipeline.
   assign w_credits = CW'(r_count) + CW'(r_s1_v) + CW'(r_s2_v);
   assign w_af_next = (int'(w_credits) + AF_MARGIN >= DEPTH);

   assign almost_full  = r_af;
   assign err_range    = r_err_range;
   assign err_overflow = r_err_overflow;

   // almost_full is registered; error flags set and hold until reset.
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_af           <= 1'b0;
         r_err_range    <= 1'b0;
         r_err_overflow <= 1'b0;
      end else begin
         r_af <= w_af_next;
         if (r_s2_v && r_s2_rng) begin
            r_err_range <= 1'b1;
         end
         if (w_drop) begin
            r_err_overflow <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qpmm_final_reducer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qpmm_final_reducer
//  Description : Self-checking bench for qpmm_final_reducer with directed
//                scenarios and randomized traffic against a modular-arithmetic
//                reference model with a transaction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qpmm_final_reducer;

   localparam int             W_IN      = 256;
   localparam int             W_P       = 254;
   localparam int             W_TAG     = 8;
   localparam int             DEPTH     = 8;
   localparam int             AF_MARGIN = 2;
   localparam logic [W_P-1:0] P = 254'h2523648240000001ba344d80000000086121000000000013a700000000000013;
   localparam logic [W_IN:0]  PX  = {3'b000, P};
   localparam logic [W_IN:0]  P2X = PX * 2;
   localparam logic [W_IN:0]  P4X = PX * 4;

   logic              clk = 1'b0;
   logic              rstn;
   logic              in_valid;
   logic [W_IN-1:0]   in_z;
   logic [W_TAG-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [W_P-1:0]    out_data;
   logic [W_TAG-1:0]  out_tag;
   logic              almost_full;
   logic              err_range;
   logic              err_overflow;
   logic [3:0]        count;

   always #5 clk = ~clk;

   qpmm_final_reducer #(
      .W_IN(W_IN), .W_P(W_P), .P(P), .W_TAG(W_TAG), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_z(in_z), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
      .almost_full(almost_full), .err_range(err_range), .err_overflow(err_overflow),
      .count(count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [W_P-1:0]   d;
      logic [W_TAG-1:0] t;
      logic             rng;
   } ent_t;

   ent_t mq[$];
   ent_t p1, p2;
   logic p1_v, p2_v;
   logic m_af, m_err_range, m_err_ovf;

   function automatic ent_t ref_reduce(input logic [W_IN-1:0] z, input logic [W_TAG-1:0] t);
      ent_t e;
      logic [W_IN:0] zz;
      logic [W_IN:0] r;
      zz    = {1'b0, z};
      e.t   = t;
      e.rng = (zz >= P4X);
      if (!e.rng) r = zz % PX;
      else        r = zz - 3 * PX;
      e.d   = r[W_P-1:0];
      return e;
   endfunction

   task automatic model_clear();
      mq.delete();
      p1_v = 1'b0; p2_v = 1'b0;
      p1 = '0; p2 = '0;
      m_af = 1'b0; m_err_range = 1'b0; m_err_ovf = 1'b0;
   endtask

   task automatic model_edge();
      int  used;
      bit  pop;
      bit  full;
      used = mq.size() + int'(p1_v) + int'(p2_v);
      pop  = (mq.size() > 0) && out_ready;
      full = (mq.size() == DEPTH);
      m_af = ((DEPTH - used) <= AF_MARGIN);
      if (p2_v && p2.rng) m_err_range = 1'b1;
      if (pop) void'(mq.pop_front());
      if (p2_v) begin
         if (!full || pop) mq.push_back(p2);
         else              m_err_ovf = 1'b1;
      end
      p2_v = p1_v;
      p2   = p1;
      p1_v = in_valid;
      p1   = ref_reduce(in_z, in_tag);
   endtask

   // One clock: drive inputs, advance model at the edge, return on negedge.
   task automatic cycle(input logic v, input logic [W_IN-1:0] z, input logic [W_TAG-1:0] t, input logic r);
      in_valid  = v;
      in_z      = z;
      in_tag    = t;
      out_ready = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      model_clear();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
      n_checks++; if (err_range !== 1'b0 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", err_range, err_overflow); end
      n_checks++; if (out_data !== '0 || out_tag !== '0) begin n_fail++; $display("FAIL reset_head: got %h/%h want 0/0", out_data, out_tag); end
   endtask

   task automatic test_basic();
      cycle(1'b1, 256'd5, 8'h11, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got %b want 0", out_valid); end
      cycle(1'b1, P2X[W_IN-1:0] >> 1, 8'h12, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat2: got %b want 0", out_valid); end
      cycle(1'b1, W_IN'(P2X + 7), 8'h13, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 254'd5 || out_tag !== 8'h11)
         begin n_fail++; $display("FAIL basic_first: got v=%b %h/%h want v=1 5/11", out_valid, out_data, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 254'd0 || out_tag !== 8'h12)
         begin n_fail++; $display("FAIL basic_second: got v=%b %h/%h want v=1 0/12", out_valid, out_data, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 254'd7 || out_tag !== 8'h13)
         begin n_fail++; $display("FAIL basic_third: got v=%b %h/%h want v=1 7/13", out_valid, out_data, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_upper_bound();
      cycle(1'b1, W_IN'(P4X - 1), 8'h21, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== P - 254'd1 || out_tag !== 8'h21)
         begin n_fail++; $display("FAIL upper_data: got v=%b %h want %h", out_valid, out_data, P - 254'd1); end
      n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL upper_err_range: got %b want 0", err_range); end
      cycle(1'b0, '0, '0, 1'b1);
   endtask

   task automatic test_range_error();
      cycle(1'b1, P4X[W_IN-1:0], 8'h7F, 1'b1);
      cycle(1'b1, 256'd5, 8'h80, 1'b1);
      n_checks++; if (err_range !== 1'b0) begin n_fail++; $display("FAIL range_early: got %b want 0", err_range); end
      cycle(1'b1, 256'd6, 8'h81, 1'b1);
      n_checks++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL range_set: got %b want 1", err_range); end
      n_checks++; if (out_valid !== 1'b1 || out_tag !== 8'h7F) begin n_fail++; $display("FAIL range_tag: got v=%b %h want v=1 7f", out_valid, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_data !== 254'd5 || out_tag !== 8'h80) begin n_fail++; $display("FAIL range_next: got %h/%h want 5/80", out_data, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (err_range !== 1'b1) begin n_fail++; $display("FAIL range_sticky: got %b want 1", err_range); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 1; i <= 9; i++) begin
         cycle(1'b1, W_IN'(i), W_TAG'(i), 1'b0);
         if (i == 6) begin
            n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL fill_af_c6: got %b want 0", almost_full); end
         end
         if (i == 7) begin
            n_checks++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_af_c7: got %b want 1", almost_full); end
         end
      end
      cycle(1'b0, '0, '0, 1'b0);
      n_checks++; if (count !== 4'd8 || err_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count=%0d ovf=%b want 8 0", count, err_overflow); end
      cycle(1'b0, '0, '0, 1'b0);
      n_checks++; if (count !== 4'd8 || err_overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got count=%0d ovf=%b want 8 1", count, err_overflow); end
      for (int i = 1; i <= 8; i++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== W_P'(i) || out_tag !== W_TAG'(i))
            begin n_fail++; $display("FAIL fill_drain_%0d: got v=%b %h/%h want %0d", i, out_valid, out_data, out_tag, i); end
         cycle(1'b0, '0, '0, 1'b1);
      end
      n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL fill_drained: got v=%b count=%0d want 0 0", out_valid, count); end
   endtask

   task automatic test_push_pop_full();
      do_reset();
      for (int i = 1; i <= 9; i++) cycle(1'b1, W_IN'(i), W_TAG'(i), 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL pp_count: got %0d want 8", count); end
      n_checks++; if (err_overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow: got %b want 0", err_overflow); end
      for (int i = 2; i <= 9; i++) begin
         n_checks++; if (out_valid !== 1'b1 || out_data !== W_P'(i))
            begin n_fail++; $display("FAIL pp_drain_%0d: got v=%b %h want %0d", i, out_valid, out_data, i); end
         cycle(1'b0, '0, '0, 1'b1);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, P4X[W_IN-1:0], 8'h01, 1'b0);
      for (int i = 2; i <= 5; i++) cycle(1'b1, W_IN'(i), W_TAG'(i), 1'b0);
      in_valid = 1'b0;
      n_checks++; if (count !== 4'd3 || err_range !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got count=%0d rng=%b want 3 1", count, err_range); end
      #2 rstn = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL mid_async: got v=%b count=%0d want 0 0", out_valid, count); end
      n_checks++; if (err_range !== 1'b0 || err_overflow !== 1'b0 || almost_full !== 1'b0)
         begin n_fail++; $display("FAIL mid_flags: got %b%b%b want 000", err_range, err_overflow, almost_full); end
      @(negedge clk);
      rstn = 1'b0;
      model_clear();
      cycle(1'b1, 256'd42, 8'h42, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1: got %b want 0", out_valid); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat2: got %b want 0", out_valid); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b1 || out_data !== 254'd42 || out_tag !== 8'h42)
         begin n_fail++; $display("FAIL mid_42: got v=%b %h/%h want 42/42", out_valid, out_data, out_tag); end
      cycle(1'b0, '0, '0, 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_alone: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      logic [W_IN-1:0] zr;
      logic            v, r;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 8; k++) zr[k*32 +: 32] = $urandom;
         if ($urandom_range(15) != 0) zr = W_IN'({1'b0, zr} % P4X);
         v = ($urandom_range(3) != 0);
         if (c < 150)      r = ($urandom_range(2) == 0);
         else if (c < 370) r = ($urandom_range(3) != 0);
         else              r = 1'b1;
         if (c >= 370) v = 1'b0;
         cycle(v, zr, W_TAG'($urandom), r);
         n_checks++; if (out_valid !== (mq.size() > 0) || count !== 4'(mq.size()))
            begin n_fail++; $display("FAIL rnd_occ c=%0d: got v=%b count=%0d want count=%0d", c, out_valid, count, mq.size()); end
         n_checks++; if (almost_full !== m_af || err_range !== m_err_range || err_overflow !== m_err_ovf)
            begin n_fail++; $display("FAIL rnd_flags c=%0d: got af/rng/ovf=%b%b%b want %b%b%b", c, almost_full, err_range, err_overflow, m_af, m_err_range, m_err_ovf); end
         if (mq.size() > 0) begin
            n_checks++; if (out_data !== mq[0].d || out_tag !== mq[0].t)
               begin n_fail++; $display("FAIL rnd_head c=%0d: got %h/%h want %h/%h", c, out_data, out_tag, mq[0].d, mq[0].t); end
         end
      end
   endtask

   initial begin
      rstn = 1'b1; in_valid = 1'b0; in_z = '0; in_tag = '0; out_ready = 1'b0;
      model_clear();
      @(negedge clk);
      test_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_upper_bound();
      test_range_error();
      test_fill_overflow();
      test_push_pop_full();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/qpmm_final_reducer.md
Name: qpmm_final_reducer

Overview:
- Sits directly downstream of the BN254 QPMM multiplier. Takes its redundant-range product Z, which is lazily reduced and guaranteed below 4p.
- Canonicalises Z into [0, p) with a two-stage pipelined conditional subtraction (2p, then p), carrying a tag alongside.
- Buffers results in a show-ahead FIFO with valid/ready output. The multiplier cannot stall, so the block also exports almost_full for the issue logic and sticky error flags.

Parameters:
- W_IN, 256, width of incoming Z.
- W_P, 254, modulus width and output data width.
- P, 254'h2523648240000001ba344d80000000086121000000000013a700000000000013, BN254 base-field modulus.
- W_TAG, 8, width of the opaque tag.
- DEPTH, 8, FIFO entries (power of two, ≥4).
- AF_MARGIN, 2, almost_full asserts when free credits ≤ AF_MARGIN.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rstn, input, 1, asynchronous reset, active-high (asserted = 1), despite the name.
- in_valid, input, 1, Z valid this cycle; no backpressure on this side.
- in_z, input, W_IN, raw QPMM product.
- in_tag, input, W_TAG, tag travelling with in_z.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, consumer accepts head.
- out_data, output, W_P, canonical result in [0, p).
- out_tag, output, W_TAG, tag of the head entry.
- almost_full, output, 1, issue-throttle hint.
- err_range, output, 1, sticky: an input with in_z ≥ 4p was seen.
- err_overflow, output, 1, sticky: a result was dropped because the FIFO was full.
- count, output, $clog2(DEPTH)+1, FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, almost_full, err_range and err_overflow go to 0; count goes to 0.
  - out_data/out_tag read as 0; pipeline valids clear; FIFO pointers go to 0.
  - Reset mid-operation discards all in-flight and buffered entries.
- Stage 1, registered at the edge after in_valid:
  - d = in_z − 2P, computed W_IN+1 bits wide.
  - s1_z = d when in_z ≥ 2P (no borrow), else in_z.
  - s1_rng = (in_z ≥ 4P).
  - s1_tag and s1_v are also registered.
- Stage 2, registered one edge later:
  - s2_z = s1_z − P when s1_z ≥ P, else s1_z; truncated to W_P bits.
  - s2_v, s2_tag and s2_rng are registered.
- err_range sets on the edge where s2_v && s2_rng. The entry is still written, with data = the truncated algorithmic result; the value is meaningless but the tag is preserved.
- FIFO write occurs on the edge where s2_v = 1. FIFO pop occurs on the edge where out_valid && out_ready.
- Latency: in_valid in cycle t gives out_valid = 1 in cycle t+3 if the FIFO was empty and out_ready did not matter earlier (show-ahead head, no bypass).
- Throughput: one input per cycle; order is strictly preserved.
- Full FIFO:
  - If a write and a pop occur in the same cycle, both succeed; count is unchanged and there is no overflow.
  - If a write occurs without a pop, the entry is dropped, err_overflow sets and count stays DEPTH.
- Empty FIFO: out_valid = 0; out_ready is ignored and a pop is a no-op.
- out_data/out_tag may hold any value while out_valid = 0. While out_valid = 1 and out_ready = 0 they must be stable.
- Credits and almost_full:
  - credits_used = count + s1_v + s2_v.
  - almost_full = (DEPTH − credits_used ≤ AF_MARGIN), registered. This is one cycle late, which is accounted for by AF_MARGIN ≥ 2.
- Sticky flags clear only on reset.
- Widths:
  - Comparisons are performed via the borrow out of a W_IN+1-bit subtraction.
  - 2P and 4P are zero-extended to W_IN+1 bits.
  - No truncation occurs before stage 2.

Test Plan:
- Basic reduction:
  - Stimulus: in_z=5, tag=0x11; then in_z=P, tag=0x12; then in_z=2P+7, tag=0x13, with out_ready=1.
  - Response: outputs 5/0x11, 0/0x12, 7/0x13 in order; first out_valid 3 cycles after the first in_valid.
- Upper bound:
  - Stimulus: in_z=4P−1.
  - Response: out_data=P−1; err_range stays 0.
- Range error:
  - Stimulus: in_z=4P, tag=0x7F.
  - Response: entry emitted with tag 0x7F; err_range=1 from that write edge onward; it holds through subsequent valid inputs.
- Fill and overflow:
  - Stimulus: out_ready=0; 9 back-to-back inputs z=1..9.
  - Response: almost_full rises when credits_used reaches 6; count saturates at 8; err_overflow=1 after the 9th write edge.
  - Then raise out_ready: the drain returns 1..8 in order.
- Push and pop at full:
  - Stimulus: FIFO full; out_ready=1 in the same cycle as a stage-2 write.
  - Response: count stays 8; err_overflow stays 0; the head advances.
- Reset mid-stream:
  - Stimulus: 3 entries buffered and 2 in flight; assert rstn=1 asynchronously between clock edges.
  - Response: out_valid, count and the flags drop to 0 immediately; after release, the next input (z=42) emerges alone 3 cycles later.
